coreriscv_axi4_meta_writer: RTL
===============================

// Module: coreriscv_axi4_meta_writer
// PURPOSE
//  Consumes the granted output of the 3-way L1 D-cache metadata-write arbiter and drives the tag/coherence array write port.
//  - Out of reset, sweeps every set and writes coh_state=0 (invalid) to clear the array.
//  - Then buffers arbiter grants in a small in-order queue and retires one per cycle whenever the array port is free.
// PARAMETERS
//  IDX_W   7    set-index width; SETS = 2**IDX_W
//  TAG_W   19   tag width
//  COH_W   2    coherence-state width
//  DEPTH   2    queue entries; power of two, >=1
// PORTS
//  clk                        in   1      core clock
//  reset                      in   1      asynchronous, active-high reset
//  io_in_ready                out  1      queue can accept (to arbiter io_out_ready)
//  io_in_valid                in   1      arbiter grant valid
//  io_in_bits_idx             in   IDX_W  set index
//  io_in_bits_way_en          in   1      way write enable
//  io_in_bits_data_tag        in   TAG_W  tag to write
//  io_in_bits_data_coh_state  in   COH_W  coherence state to write
//  io_array_busy              in   1      array port taken by the read pipe this cycle; no write allowed
//  io_meta_wen                out  1      array write strobe
//  io_meta_addr               out  IDX_W  array write address
//  io_meta_wmask              out  1      per-way write mask
//  io_meta_wdata              out  META_W {parity?, tag, coh_state}
//  io_init_done               out  1      registered; 1 once the sweep completes
//  io_count                   out  $clog2(DEPTH+1)  queue occupancy
// BEHAVIOUR
//  Clocking and reset
//  - One clock. reset is asynchronous, active-high; asserting it at any time discards queue contents and re-enters INIT.
//  States
//  - INIT: sweep in progress. RUN: normal operation. No return from RUN to INIT except by reset.
//  Reset values
//  - state=INIT, init_ctr=0, head=tail=count=0, io_init_done=0, io_in_ready=0.
//  - io_meta_addr=0, io_meta_wdata=0, io_meta_wmask=1, io_meta_wen=!io_array_busy.
//  INIT
//  - io_in_ready=0.
//  - io_meta_wen=!io_array_busy, io_meta_addr=init_ctr, io_meta_wmask=1, io_meta_wdata=0 (parity bit 0).
//  - init_ctr increments only on cycles where wen=1.
//  - On a write with init_ctr==SETS-1: next state=RUN and io_init_done=1 on that clock edge.
//  - io_array_busy stalls the sweep without skipping a set.
//  RUN, enqueue
//  - io_in_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from io_array_busy.
//  - Enqueue on io_in_valid & io_in_ready.
//  RUN, dequeue
//  - When count!=0 and !io_array_busy: io_meta_wen=1, with addr/wmask/wdata taken from the head entry. The head dequeues on that edge.
//  - When there is no write, io_meta_wen=0 and addr/wmask/wdata hold the head entry (don't-care, but X-free).
//  Queue rules
//  - No bypass: minimum latency from accept to wen is 1 cycle.
//  - Simultaneous enq+deq with 0<count<DEPTH: count unchanged.
//  - When full, a same-cycle dequeue does NOT make io_in_ready=1 that cycle.
//  - Pointers wrap modulo DEPTH. Strict FIFO order; no coalescing of same-idx entries.
//  - way_en=0 entries still consume one write slot, with wmask=0.
// CONFIGURATION
//  CORERISCV_AXI4_META_PARITY_EN
//  - Defined: META_W = TAG_W+COH_W+1; wdata MSB = ^{tag,coh} (even parity); sweep writes parity 0.
//  - Undefined: META_W = TAG_W+COH_W; no parity logic.
// STRUCTURE
//  Package coreriscv_axi4_meta_pkg
//  - State encoding (INIT=1'b0, RUN=1'b1).
//  - META_W localparam under the macro.
//  - Meta-entry packing function {idx, way_en, tag, coh}.
//  Sub-module coreriscv_axi4_meta_fifo
//  - Parameterised DEPTH x entry-width register FIFO: enq/deq, count, full/empty.
//  - Top level holds the INIT/RUN FSM, sweep counter, write-port mux and parity.
// TESTING
//  1. Reset, busy=0 throughout -> 128 consecutive wen cycles with addr 0..127, wdata 0; init_done=1 and in_ready=1 from cycle 128.
//  2. busy=1 for sweep cycles 10..14 -> addr holds at 10 during the stall, no set skipped; init_done asserts 5 cycles later than in test 1.
//  3. RUN: idx=0x25, way_en=1, tag=0x1ABCD, coh=2'b10 accepted -> next cycle wen=1, addr=0x25, wmask=1, wdata={0x1ABCD,2'b10}.
//  4. busy=1 with three back-to-back valids -> two accepted, in_ready=0, count=2; release busy -> writes in arrival order, then third accepted.
//  5. Reset asserted mid-RUN with count=2 -> count=0 and init_done=0 immediately; sweep restarts at addr 0; queued entries never written.
//  6. PARITY_EN defined: tag=0x00001, coh=0 -> wdata[21]=1; tag=0x00003, coh=0 -> wdata[21]=0.

Source files
------------

// File: rtl/coreriscv_axi4_meta_pkg.sv
// Shared types and widths for the L1 D-cache metadata write port.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Optional feature macro: CORERISCV_AXI4_META_PARITY_EN adds one even-parity
// bit as the MSB of the array write data.
package coreriscv_axi4_meta_pkg;

  localparam int IDX_W = 7;
  localparam int TAG_W = 19;
  localparam int COH_W = 2;
  localparam int SETS  = 1 << IDX_W;

`ifdef CORERISCV_AXI4_META_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int META_W = TAG_W + COH_W + PAR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One queued arbiter grant, packed as {idx, way_en, tag, coh}.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             way_en;
    logic [TAG_W-1:0] tag;
    logic [COH_W-1:0] coh;
  } meta_entry_t;

  localparam int ENTRY_W = $bits(meta_entry_t);

  function automatic meta_entry_t pack_entry(
    input logic [IDX_W-1:0] idx,
    input logic             way_en,
    input logic [TAG_W-1:0] tag,
    input logic [COH_W-1:0] coh
  );
    meta_entry_t e;
    e.idx    = idx;
    e.way_en = way_en;
    e.tag    = tag;
    e.coh    = coh;
    return e;
  endfunction

endpackage

// File: rtl/coreriscv_axi4_meta_fifo.sv
// Small in-order register FIFO, DEPTH entries of W bits, no bypass.
// Latency: data enqueued on an edge is visible at the head the following cycle.
// Backpressure: enq is ignored while full, deq is ignored while empty.
// Ports: clk/rst; enq + enq_data push; deq pops head_data; count, full, empty
// all derived from registered state only.
module coreriscv_axi4_meta_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq,
  input  logic [W-1:0]               enq_data,
  input  logic                       deq,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          do_enq;
  logic          do_deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_enq    = enq & ~full;
  assign do_deq    = deq & ~empty;
  assign head_data = mem[head];

  // Storage is reset too so the head is never X while the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_enq) begin
      mem[tail] <= enq_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= ptr_inc(tail);
      if (do_deq) head <= ptr_inc(head);
      case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coreriscv_axi4_meta_writer.sv
// Drives the tag/coherence array write port: clears every set after reset,
// then retires queued metadata-arbiter grants one per free array cycle.
// Latency: accept to array write is at least 1 cycle (no bypass).
// Backpressure: io_in_ready is low during the sweep and while the queue is
// full; it comes from registered state only, never from io_array_busy.
// Ports: clk, reset (async, active-high); io_in_* arbiter grant handshake;
// io_array_busy stalls writes; io_meta_* array write port; io_init_done,
// io_count status.
// Optional feature macro: CORERISCV_AXI4_META_PARITY_EN (even-parity MSB on wdata).
module coreriscv_axi4_meta_writer
  import coreriscv_axi4_meta_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       io_in_ready,
  input  logic                       io_in_valid,
  input  logic [IDX_W-1:0]           io_in_bits_idx,
  input  logic                       io_in_bits_way_en,
  input  logic [TAG_W-1:0]           io_in_bits_data_tag,
  input  logic [COH_W-1:0]           io_in_bits_data_coh_state,
  input  logic                       io_array_busy,
  output logic                       io_meta_wen,
  output logic [IDX_W-1:0]           io_meta_addr,
  output logic                       io_meta_wmask,
  output logic [META_W-1:0]          io_meta_wdata,
  output logic                       io_init_done,
  output logic [$clog2(DEPTH+1)-1:0] io_count
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] init_ctr;
  logic             sweep_wr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_enq;
  logic             fifo_deq;
  logic [ENTRY_W-1:0] fifo_head;
  meta_entry_t      head;
  logic [META_W-1:0] run_wdata;

  assign sweep_wr = (state == ST_INIT) & ~io_array_busy;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // FSM: next state. Leaves INIT on the write of the last set.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (sweep_wr && (init_ctr == '1)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Sweep counter advances only on cycles that actually write, so a busy
  // array stalls the sweep without skipping a set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         init_ctr <= '0;
    else if (sweep_wr) init_ctr <= init_ctr + 1'b1;
  end

  assign io_init_done = (state == ST_RUN);
  assign io_in_ready  = (state == ST_RUN) & ~fifo_full;
  assign fifo_enq     = io_in_valid & io_in_ready;
  assign fifo_deq     = (state == ST_RUN) & io_meta_wen;

  coreriscv_axi4_meta_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .enq       (fifo_enq),
    .enq_data  (pack_entry(io_in_bits_idx, io_in_bits_way_en,
                           io_in_bits_data_tag, io_in_bits_data_coh_state)),
    .deq       (fifo_deq),
    .head_data (fifo_head),
    .count     (io_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head = fifo_head;

`ifdef CORERISCV_AXI4_META_PARITY_EN
  assign run_wdata = {^{head.tag, head.coh}, head.tag, head.coh};
`else
  assign run_wdata = {head.tag, head.coh};
`endif

  // FSM: outputs. In RUN the port always shows the head entry; only wen
  // decides whether it is actually written.
  always_comb begin
    io_meta_wen   = 1'b0;
    io_meta_addr  = head.idx;
    io_meta_wmask = head.way_en;
    io_meta_wdata = run_wdata;
    case (state)
      ST_INIT: begin
        io_meta_wen   = ~io_array_busy;
        io_meta_addr  = init_ctr;
        io_meta_wmask = 1'b1;
        io_meta_wdata = '0;
      end
      ST_RUN: begin
        io_meta_wen = ~fifo_empty & ~io_array_busy;
      end
      default: ;
    endcase
  end

endmodule
